// File: rtl/rand_arbiter.sv
// rand_arbiter: shares one free-running 8-bit XNOR LFSR among NREQ requesters.
// Each granted requester receives one LFSR sample reduced modulo SPAN (by
// repeated subtraction) and offset by LO, delivered with a one-cycle ack.
// Build option: define RAND_ARB_FIXED_PRIO_EN for lowest-index-wins selection
// instead of the default round-robin; timing and data are identical in both.
module rand_arbiter #(
   parameter int         NREQ = 4,       // number of requesters, 2..8
   parameter logic [7:0] LO   = 8'd20,   // lowest returned value
   parameter logic [7:0] SPAN = 8'd120   // distinct returned values, LO+SPAN-1 <= 255
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] ack,
   output logic [7:0]      rand_val,
   output logic            busy
);

   localparam int IDXW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REDUCE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [7:0]      ps;        // LFSR state, steps every cycle
   logic [7:0]      acc;       // sample being reduced modulo SPAN
   logic [IDXW-1:0] idx;       // latched winner of the current draw
   logic [IDXW-1:0] win;       // combinational winner for this IDLE cycle
   logic            win_vld;
   logic            finish;    // REDUCE cycle that produces the result

   assign finish = (state == REDUCE) && (acc < SPAN);
   assign busy   = (state != IDLE);

   // Free-running LFSR; XNOR feedback keeps all-ones unreachable from reset value 0.
   always_ff @(posedge Clock) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values of the others, whatever the statement order.
      if (Reset) ps <= 8'h00;
      else       ps <= {ps[6:0], ~(ps[7] ^ ps[5] ^ ps[4] ^ ps[3])};
   end

`ifdef RAND_ARB_FIXED_PRIO_EN

   // Fixed priority: the lowest-index active request wins.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[IDXW'(i)]) begin
            win     = IDXW'(i);
            win_vld = 1'b1;
         end
      end
   end

`else

   logic [IDXW-1:0] last;      // most recently served requester

   // Round-robin: scan upward from last+1 with wrap; the smallest offset wins,
   // so offsets are visited high-to-low and the final hit is kept.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int i = NREQ; i >= 1; i--) begin
         if (req[IDXW'(wrap_idx(int'(last) + i))]) begin
            win     = IDXW'(wrap_idx(int'(last) + i));
            win_vld = 1'b1;
         end
      end
   end

   // Remember who was served so the next scan starts just above it.
   always_ff @(posedge Clock) begin
      if (Reset)       last <= IDXW'(NREQ - 1);
      else if (finish) last <= idx;
   end

   function automatic int wrap_idx(input int v);
      return (v >= NREQ) ? v - NREQ : v;
   endfunction

`endif

   // FSM state register.
   always_ff @(posedge Clock) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   // FSM next-state logic.
   always_comb begin
      // NOTE: assign a default before the case so no path leaves the output
      // unassigned, which would otherwise infer a latch.
      state_next = state;
      case (state)
         IDLE:    if (win_vld) state_next = REDUCE;
         REDUCE:  if (acc < SPAN) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: latch the sample, subtract SPAN until in range, publish result.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         acc      <= 8'h00;
         idx      <= '0;
         ack      <= '0;
         rand_val <= 8'h00;
      end else begin
         ack <= '0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  idx <= win;
                  acc <= ps;
               end
            end
            REDUCE: begin
               if (acc >= SPAN) begin
                  acc <= acc - SPAN;
               end else begin
                  rand_val <= LO + acc;
                  ack      <= {{(NREQ-1){1'b0}}, 1'b1} << idx;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
